// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) drives the hazard inputs; the controller side (slave) drives stall/flush/redirect.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_use_rs1;
    logic             i_id_use_rs2;
    logic             i_ex_valid;
    logic             i_ex_is_load;
    logic [4:0]       i_ex_rd;
    logic             i_ex_redirect;
    logic [31:0]      i_ex_target;
    logic             i_mem_req;
    logic             i_mem_ack;

    logic             o_pc_stall;
    logic             o_if_id_stall;
    logic             o_id_ex_stall;
    logic             o_ex_mem_stall;
    logic             o_if_id_flush;
    logic             o_id_ex_flush;
    logic             o_redirect_valid;
    logic [31:0]      o_redirect_pc;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_cycles;
    logic [CNT_W-1:0] o_redirects;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        output i_ex_valid, i_ex_is_load, i_ex_rd, i_ex_redirect, i_ex_target,
        output i_mem_req, i_mem_ack,
        input  o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall,
        input  o_if_id_flush, o_id_ex_flush, o_redirect_valid, o_redirect_pc,
        input  o_state, o_stall_cycles, o_redirects
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        input  i_ex_valid, i_ex_is_load, i_ex_rd, i_ex_redirect, i_ex_target,
        input  i_mem_req, i_mem_ack,
        output o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall,
        output o_if_id_flush, o_id_ex_flush, o_redirect_valid, o_redirect_pc,
        output o_state, o_stall_cycles, o_redirects
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline, with saturating
// stall-cycle and redirect counters. Controls are combinational; state and counters are registered.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic             memstall;
    logic             loaduse;
    logic             run_rules;
    logic             freeze;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirects;

    assign memstall = bus.i_mem_req & ~bus.i_mem_ack;
    assign loaduse  = bus.i_ex_valid & bus.i_ex_is_load & (bus.i_ex_rd != 5'd0) &
                      ((bus.i_id_use_rs1 & (bus.i_id_rs1 == bus.i_ex_rd)) |
                       (bus.i_id_use_rs2 & (bus.i_id_rs2 == bus.i_ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // MEM_WAIT leaves on the ack cycle, going to FLUSH if a held redirect is taken then.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (memstall) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (bus.i_ex_redirect) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.i_mem_ack) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (bus.i_ex_redirect) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        run_rules      = 1'b0;
        freeze         = 1'b0;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (!rst) begin
            case (state)
                ST_RUN:      if (memstall) freeze = 1'b1; else run_rules = 1'b1;
                ST_MEM_WAIT: if (!bus.i_mem_ack) freeze = 1'b1; else run_rules = 1'b1;
                ST_FLUSH:    if_id_flush = 1'b1;
                default:     ;
            endcase
            // Redirect outranks load-use: the ID instruction is on the wrong path anyway.
            if (run_rules) begin
                if (bus.i_ex_redirect) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = bus.i_ex_target;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                end else if (loaduse) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            if (freeze) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            redirects    <= '0;
        end else begin
            if (pc_stall && stall_cycles != CNT_MAX) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (redirect_valid && redirects != CNT_MAX) begin
                redirects <= redirects + CNT_ONE;
            end
        end
    end

    assign bus.o_pc_stall       = pc_stall;
    assign bus.o_if_id_stall    = if_id_stall;
    assign bus.o_id_ex_stall    = freeze;
    assign bus.o_ex_mem_stall   = freeze;
    assign bus.o_if_id_flush    = if_id_flush;
    assign bus.o_id_ex_flush    = id_ex_flush;
    assign bus.o_redirect_valid = redirect_valid;
    assign bus.o_redirect_pc    = redirect_pc;
    assign bus.o_state          = state;
    assign bus.o_stall_cycles   = stall_cycles;
    assign bus.o_redirects      = redirects;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default-width instance plus a CNT_W=4
// instance fed the same inputs, used for the saturation case.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [6:0] CTL_NONE   = 7'b0000000;
    localparam logic [6:0] CTL_FREEZE = 7'b1111000;
    localparam logic [6:0] CTL_LU     = 7'b1100010;
    localparam logic [6:0] CTL_RDR    = 7'b0000111;
    localparam logic [6:0] CTL_FLUSH  = 7'b0000100;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    pipeline_hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    pipeline_hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus4.i_id_rs1      = bus16.i_id_rs1;
    assign bus4.i_id_rs2      = bus16.i_id_rs2;
    assign bus4.i_id_use_rs1  = bus16.i_id_use_rs1;
    assign bus4.i_id_use_rs2  = bus16.i_id_use_rs2;
    assign bus4.i_ex_valid    = bus16.i_ex_valid;
    assign bus4.i_ex_is_load  = bus16.i_ex_is_load;
    assign bus4.i_ex_rd       = bus16.i_ex_rd;
    assign bus4.i_ex_redirect = bus16.i_ex_redirect;
    assign bus4.i_ex_target   = bus16.i_ex_target;
    assign bus4.i_mem_req     = bus16.i_mem_req;
    assign bus4.i_mem_ack     = bus16.i_mem_ack;

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, redirect_valid}
    function automatic logic [6:0] ctl16();
        return {bus16.o_pc_stall, bus16.o_if_id_stall, bus16.o_id_ex_stall, bus16.o_ex_mem_stall,
                bus16.o_if_id_flush, bus16.o_id_ex_flush, bus16.o_redirect_valid};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        bus16.i_id_rs1      = 5'd0;
        bus16.i_id_rs2      = 5'd0;
        bus16.i_id_use_rs1  = 1'b0;
        bus16.i_id_use_rs2  = 1'b0;
        bus16.i_ex_valid    = 1'b0;
        bus16.i_ex_is_load  = 1'b0;
        bus16.i_ex_rd       = 5'd0;
        bus16.i_ex_redirect = 1'b0;
        bus16.i_ex_target   = 32'd0;
        bus16.i_mem_req     = 1'b0;
        bus16.i_mem_ack     = 1'b0;
    endtask

    task automatic set_loaduse(input logic [4:0] rd, input logic [4:0] rs1, input logic use1,
                               input logic [4:0] rs2, input logic use2);
        bus16.i_ex_valid   = 1'b1;
        bus16.i_ex_is_load = 1'b1;
        bus16.i_ex_rd      = rd;
        bus16.i_id_rs1     = rs1;
        bus16.i_id_use_rs1 = use1;
        bus16.i_id_rs2     = rs2;
        bus16.i_id_use_rs2 = use2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        // Reset forces outputs low even with active hazard inputs.
        set_idle();
        bus16.i_mem_req     = 1'b1;
        bus16.i_ex_redirect = 1'b1;
        bus16.i_ex_target   = 32'h0000_1234;
        settle();
        check_eq("rst_ctl", 32'(ctl16()), 32'(CTL_NONE));
        check_eq("rst_pc", bus16.o_redirect_pc, 32'd0);
        cyc();
        cyc();
        check_eq("rst_state", 32'(bus16.o_state), 32'd0);
        check_eq("rst_stalls", 32'(bus16.o_stall_cycles), 32'd0);
        check_eq("rst_redirects", 32'(bus16.o_redirects), 32'd0);
        rst = 1'b0;
        set_idle();

        // Load-use on rs1 and rs2, and non-hazard variants.
        set_loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        settle();
        check_eq("lu_rs1_ctl", 32'(ctl16()), 32'(CTL_LU));
        cyc();
        check_eq("lu_rs1_state", 32'(bus16.o_state), 32'd0);
        check_eq("lu_rs1_cnt", 32'(bus16.o_stall_cycles), 32'd1);
        set_loaduse(5'd5, 5'd5, 1'b0, 5'd5, 1'b1);
        settle();
        check_eq("lu_rs2_ctl", 32'(ctl16()), 32'(CTL_LU));
        cyc();
        check_eq("lu_rs2_cnt", 32'(bus16.o_stall_cycles), 32'd2);
        set_loaduse(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check_eq("lu_x0_ctl", 32'(ctl16()), 32'(CTL_NONE));
        set_loaduse(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        settle();
        check_eq("lu_unused_ctl", 32'(ctl16()), 32'(CTL_NONE));
        set_loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        bus16.i_ex_valid = 1'b0;
        settle();
        check_eq("lu_bubble_ctl", 32'(ctl16()), 32'(CTL_NONE));
        bus16.i_ex_valid   = 1'b1;
        bus16.i_ex_is_load = 1'b0;
        settle();
        check_eq("lu_notload_ctl", 32'(ctl16()), 32'(CTL_NONE));
        cyc();
        check_eq("lu_none_cnt", 32'(bus16.o_stall_cycles), 32'd2);
        set_idle();

        // Redirect, then FLUSH ignoring memstall and load-use.
        bus16.i_ex_redirect = 1'b1;
        bus16.i_ex_target   = 32'h0000_0180;
        settle();
        check_eq("rdr_ctl", 32'(ctl16()), 32'(CTL_RDR));
        check_eq("rdr_pc", bus16.o_redirect_pc, 32'h0000_0180);
        cyc();
        check_eq("rdr_state", 32'(bus16.o_state), 32'd2);
        check_eq("rdr_cnt", 32'(bus16.o_redirects), 32'd1);
        set_idle();
        bus16.i_mem_req     = 1'b1;
        bus16.i_ex_redirect = 1'b1;
        set_loaduse(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        settle();
        check_eq("flush_ctl", 32'(ctl16()), 32'(CTL_FLUSH));
        cyc();
        check_eq("flush_exit_state", 32'(bus16.o_state), 32'd0);
        check_eq("flush_rdr_cnt", 32'(bus16.o_redirects), 32'd1);
        set_idle();

        // Three-cycle memory wait, then ack.
        do_reset();
        bus16.i_mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("mw_ctl%0d", i), 32'(ctl16()), 32'(CTL_FREEZE));
            cyc();
            check_eq($sformatf("mw_state%0d", i), 32'(bus16.o_state), 32'd1);
        end
        bus16.i_mem_ack = 1'b1;
        settle();
        check_eq("mw_ack_ctl", 32'(ctl16()), 32'(CTL_NONE));
        cyc();
        check_eq("mw_ack_state", 32'(bus16.o_state), 32'd0);
        check_eq("mw_cnt", 32'(bus16.o_stall_cycles), 32'd3);
        set_idle();

        // Redirect plus load-use held across a 2-cycle wait: taken on ack.
        do_reset();
        bus16.i_mem_req     = 1'b1;
        bus16.i_ex_redirect = 1'b1;
        bus16.i_ex_target   = 32'h0000_0240;
        set_loaduse(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq($sformatf("hold_ctl%0d", i), 32'(ctl16()), 32'(CTL_FREEZE));
            cyc();
        end
        check_eq("hold_state", 32'(bus16.o_state), 32'd1);
        bus16.i_mem_ack = 1'b1;
        settle();
        check_eq("hold_ack_ctl", 32'(ctl16()), 32'(CTL_RDR));
        check_eq("hold_ack_pc", bus16.o_redirect_pc, 32'h0000_0240);
        cyc();
        check_eq("hold_flush_state", 32'(bus16.o_state), 32'd2);
        check_eq("hold_rdr_cnt", 32'(bus16.o_redirects), 32'd1);
        check_eq("hold_stall_cnt", 32'(bus16.o_stall_cycles), 32'd2);
        set_idle();
        cyc();

        // Redirect and load-use together in RUN.
        bus16.i_ex_redirect = 1'b1;
        bus16.i_ex_target   = 32'h0000_0300;
        set_loaduse(5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
        settle();
        check_eq("prio_ctl", 32'(ctl16()), 32'(CTL_RDR));
        cyc();
        check_eq("prio_state", 32'(bus16.o_state), 32'd2);
        check_eq("prio_rdr_cnt", 32'(bus16.o_redirects), 32'd2);
        check_eq("prio_stall_cnt", 32'(bus16.o_stall_cycles), 32'd2);
        set_idle();
        cyc();

        // Ack cycle with only load-use pending: one stall, back to RUN.
        bus16.i_mem_req = 1'b1;
        cyc();
        set_loaduse(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        bus16.i_mem_ack = 1'b1;
        settle();
        check_eq("ack_lu_ctl", 32'(ctl16()), 32'(CTL_LU));
        cyc();
        check_eq("ack_lu_state", 32'(bus16.o_state), 32'd0);
        set_idle();

        // Reset asserted in MEM_WAIT.
        bus16.i_mem_req = 1'b1;
        cyc();
        check_eq("rstmw_pre_state", 32'(bus16.o_state), 32'd1);
        rst = 1'b1;
        settle();
        check_eq("rstmw_ctl", 32'(ctl16()), 32'(CTL_NONE));
        cyc();
        check_eq("rstmw_state", 32'(bus16.o_state), 32'd0);
        check_eq("rstmw_stall_cnt", 32'(bus16.o_stall_cycles), 32'd0);
        check_eq("rstmw_rdr_cnt", 32'(bus16.o_redirects), 32'd0);
        rst = 1'b0;
        set_idle();

        // Reset asserted in FLUSH.
        bus16.i_ex_redirect = 1'b1;
        cyc();
        set_idle();
        rst = 1'b1;
        settle();
        check_eq("rstfl_ctl", 32'(ctl16()), 32'(CTL_NONE));
        cyc();
        check_eq("rstfl_state", 32'(bus16.o_state), 32'd0);
        rst = 1'b0;

        // 20-cycle stall: narrow counter saturates, wide one keeps counting.
        do_reset();
        bus16.i_mem_req = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        check_eq("sat_cnt4", 32'(bus4.o_stall_cycles), 32'd15);
        check_eq("sat_cnt16", 32'(bus16.o_stall_cycles), 32'd20);
        cyc();
        check_eq("sat_cnt4_hold", 32'(bus4.o_stall_cycles), 32'd15);
        bus16.i_mem_ack = 1'b1;
        cyc();
        set_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
